// File: rtl/mips_lsu_pkg.sv
// Shared types for the MIPS32 load/store unit: access size codes, FSM state
// encoding and the wait-counter width sized for the largest timeout (255).
package mips_lsu_pkg;

   localparam int MAX_WAIT_LIMIT = 255;
   localparam int CNT_W          = $clog2(MAX_WAIT_LIMIT + 1);

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } lsu_state_t;

endpackage

// File: rtl/mips_lsu_load_align.sv
// Combinational load-data lane select and sign/zero extension.
// Half accesses always take their lane from ea[1]; size 3 behaves as word.
module lsu_load_align
   import mips_lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  ea_lo,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'(mem_rdata >> {ea_lo, 3'b000});
      lane_h = ea_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size)
         SZ_BYTE: load_data = {{24{lane_b[7] & ~uns}}, lane_b};
         SZ_HALF: load_data = {{16{lane_h[15] & ~uns}}, lane_h};
         default: load_data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/mips_lsu.sv
// Multi-cycle load/store unit: forms ea = base + offset and runs one ready/valid
// memory transaction per request. Define MIPS_LSU_ALIGN_CHECK_EN to trap misaligned accesses.
//
// state     | meaning
// ST_IDLE   | req_ready high, waiting for req_valid
// ST_ACCESS | mem_req high, waiting for mem_ready or timeout
// ST_RESP   | one-cycle done pulse with error flags
module mips_lsu
   import mips_lsu_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_base,
   input  logic [31:0] req_offset,
   input  logic [31:0] req_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        done,
   output logic [31:0] load_data,
   output logic        addr_err,
   output logic        bus_err
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   lsu_state_t       state;
   logic [1:0]       ea_lo_q;
   logic [1:0]       size_q;
   logic             uns_q;
   logic             store_q;
   logic [CNT_W-1:0] wait_cnt;

   logic [31:0] ea;
   logic [3:0]  wstrb_fmt;
   logic [31:0] wdata_fmt;
   logic        misaligned;
   logic [31:0] align_data;

   assign ea = req_base + req_offset;

   always_comb begin
      case (req_size)
         SZ_BYTE: begin
            wstrb_fmt = 4'b0001 << ea[1:0];
            wdata_fmt = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            wstrb_fmt = ea[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{req_wdata[15:0]}};
         end
         default: begin
            wstrb_fmt = 4'b1111;
            wdata_fmt = req_wdata;
         end
      endcase
      if (!req_store) wstrb_fmt = 4'b0000;
   end

`ifdef MIPS_LSU_ALIGN_CHECK_EN
   always_comb begin
      case (req_size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = ea[0];
         default: misaligned = |ea[1:0];
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   lsu_load_align u_load_align (
      .mem_rdata (mem_rdata),
      .ea_lo     (ea_lo_q),
      .size      (size_q),
      .uns       (uns_q),
      .load_data (align_data)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wstrb <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         addr_err  <= 1'b0;
         bus_err   <= 1'b0;
         load_data <= '0;
         wait_cnt  <= '0;
         ea_lo_q   <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         store_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  ea_lo_q   <= ea[1:0];
                  size_q    <= req_size;
                  uns_q     <= req_unsigned;
                  store_q   <= req_store;
                  mem_addr  <= {ea[31:2], 2'b00};
                  mem_we    <= req_store;
                  mem_wstrb <= wstrb_fmt;
                  mem_wdata <= wdata_fmt;
                  wait_cnt  <= '0;
                  req_ready <= 1'b0;
                  if (misaligned) begin
                     state    <= ST_RESP;
                     done     <= 1'b1;
                     addr_err <= 1'b1;
                  end else begin
                     state   <= ST_ACCESS;
                     mem_req <= 1'b1;
                  end
               end
            end
            ST_ACCESS: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_RESP;
                  if (!store_q) load_data <= align_data;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  // wait_cnt counts completed idle cycles; the last one aborts
                  if (wait_cnt == WAIT_LAST) begin
                     mem_req <= 1'b0;
                     done    <= 1'b1;
                     bus_err <= 1'b1;
                     state   <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               done      <= 1'b0;
               addr_err  <= 1'b0;
               bus_err   <= 1'b0;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
